// File: rtl/ws2812_iomem_queue.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_iomem_queue
// Purpose  : iomem slave that buffers CPU LED writes in a small FIFO and
//            replays them to a ws2812 driver as single-cycle led_write
//            pulses, spaced at least WRITE_GAP cycles apart.
// Ports    : clk, resetn          - clock, synchronous active-low reset
//            iomem_valid/ready    - bus handshake (ready is a 1-cycle ack)
//            iomem_wstrb/addr/wdata/rdata - bus write/read payload
//            led_num/led_rgb_data/led_write - driver write port
//            busy                 - queue non-empty or spacing in progress
// Registers: BASE+0 DATA   (write: {r,g,b,led_num}, byte-strobe merged)
//            BASE+4 STATUS ([7:0] count, [8] full, [9] empty,
//                           [16] drop_err (W1C via byte 2), [31:24] gap)
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_iomem_queue #(
  parameter logic [31:0] BASE_ADDR  = 32'h0400_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          WRITE_GAP  = 4,
  parameter int          NUM_LEDS   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  led_num,
  output logic [23:0] led_rgb_data,
  output logic        led_write,
  output logic        busy
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW       = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [8:0]  NUM_LEDS_C = 9'(NUM_LEDS);
  localparam logic [7:0]  GAP_C      = 8'(WRITE_GAP);
  localparam logic [7:0]  GAP_RELOAD = 8'(WRITE_GAP - 1);

  // Entries are stored as the merged DATA word: [7:0] led, [31:8] rgb.
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    gap;
  logic [31:0]   shadow;
  logic          drop_err;

  logic        hit;
  logic        sel_status;
  logic        is_write;
  logic        full;
  logic        empty;
  logic        data_wr;
  logic        data_wr_ok;
  logic        ack;
  logic        num_ok;
  logic        push;
  logic        pop;
  logic        drop_set;
  logic        drop_clr;
  logic [31:0] merged;
  logic [31:0] status_word;

  // Byte offset within a register is don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^iomem_addr[1:0];

  // The !iomem_ready term keeps a held request from being served twice.
  assign hit        = iomem_valid & ~iomem_ready &
                      (iomem_addr[31:3] == BASE_ADDR[31:3]);
  assign sel_status = iomem_addr[2];
  assign is_write   = |iomem_wstrb;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign merged = {iomem_wstrb[3] ? iomem_wdata[31:24] : shadow[31:24],
                   iomem_wstrb[2] ? iomem_wdata[23:16] : shadow[23:16],
                   iomem_wstrb[1] ? iomem_wdata[15:8]  : shadow[15:8],
                   iomem_wstrb[0] ? iomem_wdata[7:0]   : shadow[7:0]};

  assign num_ok     = ({1'b0, merged[7:0]} < NUM_LEDS_C);
  assign data_wr    = hit & ~sel_status & is_write;
  // Full is judged on the registered count, so a pop on this edge does not
  // admit a stalled write until the following edge.
  assign data_wr_ok = data_wr & ~full;
  assign ack        = hit & ~(data_wr & full);
  assign push       = data_wr_ok & num_ok;
  assign pop        = ~empty & (gap == 8'd0);

  assign drop_set = data_wr_ok & ~num_ok;
  assign drop_clr = hit & sel_status & iomem_wstrb[2] & iomem_wdata[16];

  assign status_word = {GAP_C, 7'd0, drop_err, 6'd0, empty, full, 8'(count)};

  assign busy = ~empty | (gap != 8'd0);

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem[wr_ptr] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready  <= 1'b0;
      iomem_rdata  <= 32'd0;
      led_num      <= 8'd0;
      led_rgb_data <= 24'd0;
      led_write    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      gap          <= 8'd0;
      shadow       <= 32'd0;
      drop_err     <= 1'b0;
    end else begin
      iomem_ready <= ack;
      iomem_rdata <= (ack & sel_status & ~is_write) ? status_word : 32'd0;

      if (data_wr_ok) begin
        shadow <= merged;
      end

      // A drop on the same edge as a clear leaves the flag set.
      if (drop_set) begin
        drop_err <= 1'b1;
      end else if (drop_clr) begin
        drop_err <= 1'b0;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        led_num      <= mem[rd_ptr][7:0];
        led_rgb_data <= mem[rd_ptr][31:8];
        led_write    <= 1'b1;
        gap          <= GAP_RELOAD;
      end else begin
        led_write <= 1'b0;
        if (gap != 8'd0) begin
          gap <= gap - 8'd1;
        end
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ws2812_iomem_queue.md
Name: ws2812_iomem_queue

Overview:
- iomem slave that decouples CPU LED writes from the ws2812 driver's single-cycle write port.
- CPU writes to a DATA register are pushed as (led_num, rgb) entries into a small FIFO.
- The FIFO drains into the driver, one led_write pulse per entry, with a programmable minimum spacing.
- Exposes a STATUS register and applies back-pressure on iomem_ready when full. Sits between the picosoc iomem bus and the ws2812 instance.

Parameters:
- BASE_ADDR, 32'h0400_0000, base of the 8-byte register window.
- FIFO_DEPTH, 8, number of entries; power of 2, 2..64.
- WRITE_GAP, 4, minimum cycles between successive led_write rising edges; 1..255.
- NUM_LEDS, 8, valid led_num range is 0..NUM_LEDS-1.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- iomem_valid  in  1  bus request
- iomem_ready  out  1  registered single-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; all-zero means read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- led_num  out  8  LED index to driver
- led_rgb_data  out  24  colour to driver, {wdata[31:24],wdata[23:16],wdata[15:8]}
- led_write  out  1  single-cycle strobe to driver
- busy  out  1  FIFO non-empty or gap counter non-zero

Behaviour:
- Reset (resetn=0 at an edge): iomem_ready=0, iomem_rdata=0, led_num=0, led_rgb_data=0, led_write=0, busy=0. Also FIFO empty (pointers and count 0), shadow=0, gap=0, drop_err=0. Applies mid-operation: queued entries are discarded and led_write is low after that edge.
- Decode: hit = iomem_valid & !iomem_ready & iomem_addr[31:3]==BASE_ADDR[31:3]. iomem_addr[2] selects DATA(0) or STATUS(1); addr[1:0] are ignored. Non-hits are never acknowledged.
- DATA write, wstrb!=0:
  - 32-bit shadow register; each strobed byte is updated from wdata, unstrobed bytes keep their previous shadow value.
  - The entry is formed from the merged value: num=merged[7:0], rgb=merged[31:8].
  - If count==FIFO_DEPTH at the sampling edge: no ready, no state change. The request is re-evaluated every cycle (CPU stalls).
  - Else: at the same edge, ready<=1, rdata<=0, shadow<=merged. If num<NUM_LEDS the entry is pushed; otherwise it is not pushed and drop_err<=1 (ready still given).
- DATA read: ready next edge, rdata=0, never stalls.
- STATUS read: ready next edge, never stalls. rdata fields:
  - [7:0] count
  - [8] full
  - [9] empty
  - [16] drop_err
  - [31:24] WRITE_GAP
  - other bits 0
- STATUS write: ready next edge. wstrb[2]&wdata[16] clears drop_err; other bits are ignored. rdata=0.
- Clear and set of drop_err on the same edge: set wins.
- Drain:
  - gap is an 8-bit down-counter.
  - At an edge where count>0 and gap==0: pop head; led_num/led_rgb_data<=head; led_write<=1; gap<=WRITE_GAP-1.
  - Otherwise led_write<=0 and gap decrements if non-zero.
  - led_num/led_rgb_data hold their last value between pulses.
- Latency: entry pushed at edge E0 into an idle queue gives led_write=1 in the cycle after E1 (one cycle after the ready pulse).
- WRITE_GAP=1 permits back-to-back pulses.
- Simultaneous push and pop at the same edge: count unchanged, FIFO ordering preserved. A push into an empty FIFO cannot pop at the same edge.
- Full is evaluated on the registered count before the edge. A pop on the same edge does not admit a stalled push until the next edge.
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- busy = (count!=0) | (gap!=0), combinational from registers.

Test Plan:
- Reset then DATA write wdata=32'h00FF8003, wstrb=4'hF: ready 1 cycle. Next cycle led_write=1 with led_num=3, led_rgb_data=24'h00FF80. Busy low WRITE_GAP cycles after the pulse.
- Eight back-to-back DATA writes (led 0..7, WRITE_GAP=4): led_write pulses exactly 4 cycles apart, in order, with correct data. STATUS count never exceeds 8.
- Fill FIFO with WRITE_GAP=255 and issue a 9th write: iomem_ready stays low until the first pop. Ready asserts the edge after count drops to 7, and the 9th entry emerges last.
- DATA write with led_num=8 (NUM_LEDS=8): ready given, no led_write, STATUS[16]=1. STATUS write wstrb=4'h4, wdata[16]=1 gives STATUS[16]=0.
- Partial write wstrb=4'h1, wdata=5 after a full write of 32'h11223307: pushed entry is led 5, rgb=24'h112233.
- Assert resetn=0 for 1 cycle with 5 entries queued mid-drain: no further led_write. STATUS reads count=0, empty=1, and all outputs are at reset values.
